dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port; the target the datapath's o_DM_* / i_DM_* signals connect to.
- Word-organised synchronous RAM with a programmable response latency, sub-word byte-lane writes and sign/zero-extended sub-word reads.
- One outstanding request at a time; used in simulation tops and FPGA builds as local data RAM.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- LATENCY, 2, cycles from request sample to o_DM_data_ready (legal range 1..16).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_DM_Addr  in  XLEN  byte address.
- i_DM_Wd  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- i_DM_f3  in  3  access size/sign (RISC-V funct3).
- i_DM_Wen  in  1  store request.
- i_DM_MemRead  in  1  load request.
- o_DM_ReadData  out  XLEN  load result, extended to XLEN.
- o_DM_data_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, latency counter 0, o_DM_data_ready=0, o_DM_ReadData=0. RAM contents are not cleared.
- Reset asserted mid-operation: abort immediately and return to IDLE. A pending store is not committed.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: at a rising edge with i_DM_Wen|i_DM_MemRead=1, latch addr, Wd, f3 and type; load counter with LATENCY-1.
  - Go to RESP if LATENCY=1, else to WAIT.
- WAIT: decrement the counter each edge. Go to RESP at the edge where the counter is 1.
- RESP: o_DM_data_ready=1 for exactly this cycle.
  - Stores commit to the RAM at the edge entering RESP.
  - Load data is registered at that same edge. It stays valid in RESP and stays stable afterwards until the next response.
- Timing: a request sampled at edge k gives o_DM_data_ready high in cycle k+LATENCY.
- RESP -> IDLE unconditionally. The request still present at the RESP edge is the old one and is ignored. A new request is sampled at the first IDLE edge, so back-to-back accesses are supported.
- Request inputs changing during WAIT/RESP have no effect; the latched values are used.
- Wen and MemRead both set: treated as a store. o_DM_ReadData returns 0 for that response.
- Word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS. Addresses outside the window wrap.
- Store lanes by f3:
  - 000 SB: byte lane addr[1:0].
  - 001 SH: half lane addr[1].
  - 010 SW: full word.
  - Other lanes untouched.
- Load by f3:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 101 LHU: zero-extend the selected half.
  - 010 LW: full word.
- Reserved f3 (011, 110, 111): treated as a word access.
- Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0): aligned down (low address bits ignored for lane select beyond access size).

Optional Feature:
- Macro: DMEM_RESP_ERR_EN.
- Defined:
  - Adds output o_DM_err (1 bit, reset 0). It pulses together with o_DM_data_ready when the latched access is any of:
    - misaligned;
    - reserved f3;
    - (addr - BASE_ADDR) >= 4*DEPTH_WORDS.
  - On error: no RAM write, o_DM_ReadData=0.
- Undefined: port absent. Alignment and wrap rules as in Behaviour.

Test Plan:
- LATENCY=2, SW addr 0x10 Wd 0xDEADBEEF, then LW 0x10 -> each ready pulses exactly 2 cycles after sample, single cycle; read returns 0xDEADBEEF.
- After the above, SB addr 0x11 Wd 0x000000A5, then LW 0x10 -> 0xDEADA5EF. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5.
- SH addr 0x22 Wd 0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001, lower half unchanged.
- Back-to-back: MemRead held continuously across two loads (0x10 then 0x14) with LATENCY=1 -> ready high in two non-adjacent cycles (IDLE cycle between); the stale request at the RESP edge is not re-accepted.
- Drop i_rst in WAIT of SW 0x30 Wd 0x12345678, then release, then LW 0x30 -> ready and ReadData 0 during reset; load returns the pre-store value.
- With DMEM_RESP_ERR_EN: LW 0x13 -> o_DM_err=1 with ready, ReadData 0. SW 0x1000 (DEPTH_WORDS=1024) -> err=1, then LW 0x0 unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the core's DM port with a fixed
// response latency. Define DMEM_RESP_ERR_EN to add the o_DM_err access-error flag.
module dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              LATENCY     = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic [XLEN-1:0] o_DM_ReadData,
`ifdef DMEM_RESP_ERR_EN
  output logic            o_DM_err,
`endif
  output logic            o_DM_data_ready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wd_q, rdata_q;
  logic [2:0]      f3_q;
  logic            store_q, load_q;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic             req, commit;
  logic [XLEN-1:0]  cur_addr, cur_wd;
  logic [2:0]       cur_f3;
  logic             cur_store, cur_load, cur_err;
  logic             sz_byte, sz_half;
  logic [IDX_W-1:0] idx;
  logic [XLEN-1:0]  word, load_val, wdata;
  logic [3:0]       be;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;

  assign req = i_DM_Wen | i_DM_MemRead;

  // With LATENCY=1 the access completes on its own sample edge, so IDLE uses the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_addr  = i_DM_Addr;
      cur_wd    = i_DM_Wd;
      cur_f3    = i_DM_f3;
      cur_store = i_DM_Wen;
      cur_load  = i_DM_MemRead & ~i_DM_Wen;
    end else begin
      cur_addr  = addr_q;
      cur_wd    = wd_q;
      cur_f3    = f3_q;
      cur_store = store_q;
      cur_load  = load_q;
    end
  end

  assign idx     = IDX_W'((cur_addr - BASE_ADDR) >> 2);
  assign sz_byte = (cur_f3 == 3'b000) || (cur_f3 == 3'b100 && !cur_store);
  assign sz_half = (cur_f3 == 3'b001) || (cur_f3 == 3'b101 && !cur_store);

`ifdef DMEM_RESP_ERR_EN
  logic [XLEN-1:0] off;
  logic            misal, rsvd;
  assign off     = cur_addr - BASE_ADDR;
  assign misal   = sz_byte ? 1'b0 : sz_half ? cur_addr[0] : |cur_addr[1:0];
  assign rsvd    = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111);
  assign cur_err = misal | rsvd | (off >= XLEN'(4 * DEPTH_WORDS));
`else
  assign cur_err = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    word     = mem[idx];
    sel_b    = word[{cur_addr[1:0], 3'b000} +: 8];
    sel_h    = word[{cur_addr[1], 4'b0000} +: 16];
    load_val = word;
    wdata    = cur_wd;
    be       = 4'b1111;
    if (sz_byte) begin
      load_val = cur_f3[2] ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      wdata    = {4{cur_wd[7:0]}};
      be       = 4'b0001 << cur_addr[1:0];
    end else if (sz_half) begin
      load_val = cur_f3[2] ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      wdata    = {2{cur_wd[15:0]}};
      be       = cur_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        cnt_d = 4'(LATENCY - 1);
        if (LATENCY == 1) state_d = S_RESP;
        else              state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_d == S_RESP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q  <= i_DM_Addr;
        wd_q    <= i_DM_Wd;
        f3_q    <= i_DM_f3;
        store_q <= i_DM_Wen;
        load_q  <= i_DM_MemRead & ~i_DM_Wen;
      end
      if (commit) rdata_q <= (cur_load && !cur_err) ? load_val : '0;
    end
  end

  // NOTE: the RAM array has no reset; i_rst only gates the write so an aborted store is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst && commit && cur_store && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_RESP_ERR_EN
  logic err_q;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) err_q <= 1'b0;
    else        err_q <= commit & cur_err;
  end
  assign o_DM_err = err_q;
`endif

  assign o_DM_data_ready = (state_q == S_RESP);
  assign o_DM_ReadData   = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array reference model;
// a second LATENCY=1 instance covers back-to-back loads.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk, rst_n;
  logic [31:0] addr, wd, rdata;
  logic [2:0]  f3;
  logic        wen, mrd, ready;
  logic [31:0] b_addr, b_wd, b_rdata;
  logic [2:0]  b_f3;
  logic        b_wen, b_mrd, b_ready;
`ifdef DMEM_RESP_ERR_EN
  logic        err, b_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [4*DEPTH];

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_DM_Addr(addr), .i_DM_Wd(wd), .i_DM_f3(f3),
    .i_DM_Wen(wen), .i_DM_MemRead(mrd), .o_DM_ReadData(rdata),
`ifdef DMEM_RESP_ERR_EN
    .o_DM_err(err),
`endif
    .o_DM_data_ready(ready)
  );

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_DM_Addr(b_addr), .i_DM_Wd(b_wd), .i_DM_f3(b_f3),
    .i_DM_Wen(b_wen), .i_DM_MemRead(b_mrd), .o_DM_ReadData(b_rdata),
`ifdef DMEM_RESP_ERR_EN
    .o_DM_err(b_err),
`endif
    .o_DM_data_ready(b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: little-endian byte array with wrap and align-down.
  function automatic int ld_size(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int st_size(input logic [2:0] f);
    if (f == 3'd0) return 1;
    if (f == 3'd1) return 2;
    return 4;
  endfunction

  function automatic int byte_base(input logic [31:0] a, input int n);
    int lane = int'(a[1:0]);
    lane = lane - (lane % n);
    return int'((a >> 2) % DEPTH) * 4 + lane;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    int n = ld_size(f);
    int b = byte_base(a, n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[b + i];
    if (f == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int n = st_size(f);
    int b = byte_base(a, n);
    for (int i = 0; i < n; i++) mb[b + i] = d[8*i +: 8];
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [2:0] f, input logic st);
`ifdef DMEM_RESP_ERR_EN
    int n = st ? st_size(f) : ld_size(f);
    return ((a % n) != 0) || (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (a >= 4 * DEPTH);
`else
    return 1'b0 & st & a[0] & f[0];
`endif
  endfunction

  // One access on u_dut; starts and ends at a negedge with the FSM idle.
  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
    logic        is_ld = r & ~w;
    logic        e     = model_err(a, f, w);
    logic [31:0] exp_rd;
    exp_rd = (is_ld && !e) ? model_load(a, f) : 32'h0;
    addr = a; wd = d; f3 = f; wen = w; mrd = r;
    @(posedge clk);
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      if (j < LAT) begin
        check("rdy_wait", {31'h0, ready}, 32'h0);
        addr = $urandom; wd = $urandom; f3 = 3'($urandom);
        wen = 1'($urandom); mrd = 1'($urandom);
      end else begin
        wen = 1'b0; mrd = 1'b0;
        check("rdy_resp", {31'h0, ready}, 32'h1);
        if (r) check("rdata_resp", rdata, exp_rd);
`ifdef DMEM_RESP_ERR_EN
        check("err_resp", {31'h0, err}, {31'h0, e});
`endif
      end
    end
    if (w && !e) model_store(a, d, f);
    @(negedge clk);
    check("rdy_idle", {31'h0, ready}, 32'h0);
    if (r) check("rdata_hold", rdata, exp_rd);
  endtask

  task automatic b_store(input logic [31:0] a, input logic [31:0] d);
    b_addr = a; b_wd = d; b_f3 = 3'd2; b_wen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_wen = 1'b0;
    check("b_st_rdy", {31'h0, b_ready}, 32'h1);
    @(negedge clk);
    check("b_st_idle", {31'h0, b_ready}, 32'h0);
  endtask

  initial begin
    logic [31:0] pre;
    logic [2:0]  ld_f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0]  st_f3s [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    rst_n = 1'b0;
    addr = '0; wd = '0; f3 = '0; wen = 1'b0; mrd = 1'b0;
    b_addr = '0; b_wd = '0; b_f3 = '0; b_wen = 1'b0; b_mrd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_b_ready", {31'h0, b_ready}, 32'h0);
`ifdef DMEM_RESP_ERR_EN
    check("rst_err", {31'h0, err}, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < DEPTH; w++) do_req(1'b1, 1'b0, 32'(w * 4), $urandom, 3'd2);

    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'd2);
    do_req(1'b0, 1'b1, 32'h10, 32'h0, 3'd2);
    check("tp_lw", rdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h11, 32'h000000A5, 3'd0);
    do_req(1'b0, 1'b1, 32'h10, 32'h0, 3'd2);
    check("tp_sb_lw", rdata, 32'hDEADA5EF);
    do_req(1'b0, 1'b1, 32'h11, 32'h0, 3'd0);
    check("tp_lb", rdata, 32'hFFFFFFA5);
    do_req(1'b0, 1'b1, 32'h11, 32'h0, 3'd4);
    check("tp_lbu", rdata, 32'h000000A5);
    pre = model_load(32'h20, 3'd2);
    do_req(1'b1, 1'b0, 32'h22, 32'h00008001, 3'd1);
    do_req(1'b0, 1'b1, 32'h22, 32'h0, 3'd1);
    check("tp_lh", rdata, 32'hFFFF8001);
    do_req(1'b0, 1'b1, 32'h22, 32'h0, 3'd5);
    check("tp_lhu", rdata, 32'h00008001);
    do_req(1'b0, 1'b1, 32'h20, 32'h0, 3'd2);
    check("tp_sh_lw", rdata, {16'h8001, pre[15:0]});

    do_req(1'b1, 1'b1, 32'h40, 32'h00000055, 3'd2);
    do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd2);
    check("both_lw", rdata, 32'h00000055);

    // Reset during WAIT of a store: the store must not land.
    pre = model_load(32'h30, 3'd2);
    addr = 32'h30; wd = 32'h12345678; f3 = 3'd2; wen = 1'b1; mrd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, ready}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    check("mid_rst_ready2", {31'h0, ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 1'b1, 32'h30, 32'h0, 3'd2);
    check("rst_store_dropped", rdata, pre);

    // Error-window / wrap cases (checked by the model in either build).
    do_req(1'b0, 1'b1, 32'h13, 32'h0, 3'd2);
    pre = model_load(32'h0, 3'd2);
    do_req(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 3'd2);
    do_req(1'b0, 1'b1, 32'h0, 32'h0, 3'd2);
`ifdef DMEM_RESP_ERR_EN
    check("oor_store_dropped", rdata, pre);
`else
    check("wrap_store", rdata, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 400; i++) begin
      int unsigned k = $urandom_range(0, 9);
      logic [31:0] a = 32'($urandom_range(0, 32'h1FFF));
      if (k < 4)      do_req(1'b1, 1'b0, a, $urandom, st_f3s[$urandom_range(0, 5)]);
      else if (k < 9) do_req(1'b0, 1'b1, a, $urandom, ld_f3s[$urandom_range(0, 7)]);
      else            do_req(1'b1, 1'b1, a, $urandom, st_f3s[$urandom_range(0, 5)]);
    end

    // Back-to-back loads on the LATENCY=1 instance with MemRead held high.
    b_store(32'h10, 32'h11112222);
    b_store(32'h14, 32'h33334444);
    b_addr = 32'h10; b_f3 = 3'd2; b_mrd = 1'b1;
    @(negedge clk);
    check("b2b_rdy1", {31'h0, b_ready}, 32'h1);
    check("b2b_data1", b_rdata, 32'h11112222);
    b_addr = 32'h14;
    @(negedge clk);
    check("b2b_gap", {31'h0, b_ready}, 32'h0);
    @(negedge clk);
    check("b2b_rdy2", {31'h0, b_ready}, 32'h1);
    check("b2b_data2", b_rdata, 32'h33334444);
    b_mrd = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'h0, b_ready}, 32'h0);
    @(negedge clk);
    check("b2b_idle2", {31'h0, b_ready}, 32'h0);
    check("b2b_hold", b_rdata, 32'h33334444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
